// File: rtl/wb_burst_to_single.sv
// Burst-to-single Wishbone bridge: replays a cache burst request as a run of
// classic single-beat slave cycles with incrementing word addresses.
module wb_burst_to_single #(
    parameter int WB_AW = 32,
    parameter int WB_DW = 32,
    parameter int BL_W  = 8
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic                 wbm_stb_i,
    input  logic [WB_AW-1:0]     wbm_adr_i,
    input  logic                 wbm_we_i,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic [WB_DW/8-1:0]   wbm_sel_i,
    input  logic [BL_W-1:0]      wbm_bl_i,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic                 wbm_ack_o,
    output logic                 wbm_lack_o,
    output logic                 wbm_err_o,
    output logic                 wbs_cyc_o,
    output logic                 wbs_stb_o,
    output logic [WB_AW-1:0]     wbs_adr_o,
    output logic                 wbs_we_o,
    output logic [WB_DW-1:0]     wbs_dat_o,
    output logic [WB_DW/8-1:0]   wbs_sel_o,
    input  logic [WB_DW-1:0]     wbs_dat_i,
    input  logic                 wbs_ack_i,
    input  logic                 wbs_err_i
);
    localparam int               SEL_W    = WB_DW / 8;
    localparam logic [WB_AW-1:0] ADR_STEP = WB_AW'(SEL_W);
    localparam logic [WB_AW-1:0] ADR_MASK = ~(WB_AW'(SEL_W - 1));

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    state_t             r_state;
    logic [WB_AW-1:0]   r_adr;
    logic               r_we;
    logic [SEL_W-1:0]   r_sel;
    logic [BL_W-1:0]    r_rem;
    logic               r_cyc;
    logic               r_abort;

    logic               w_active;
    logic               w_abort;
    logic               w_last;
    logic               w_beat_end;

    // Once the cache drops stb mid-burst the bridge stays silent upstream,
    // even if stb comes back before the outstanding slave beat finishes.
    assign w_active   = (r_state == S_XFER) && r_cyc;
    assign w_abort    = r_abort || !wbm_stb_i;
    assign w_last     = (r_rem == BL_W'(1));
    assign w_beat_end = w_active && (wbs_ack_i || wbs_err_i);

    assign wbm_ack_o  = w_active && !w_abort && wbs_ack_i && !wbs_err_i;
    assign wbm_err_o  = w_active && !w_abort && wbs_err_i;
    assign wbm_lack_o = w_active && !w_abort && (wbs_err_i || (wbs_ack_i && w_last));
    assign wbm_dat_o  = wbs_dat_i;

    assign wbs_cyc_o  = r_cyc;
    assign wbs_stb_o  = r_cyc;
    assign wbs_adr_o  = r_adr;
    assign wbs_we_o   = r_we;
    assign wbs_sel_o  = r_sel;
    assign wbs_dat_o  = wbm_dat_i;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_rem   <= '0;
            r_cyc   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wbm_stb_i) begin
                        r_adr   <= wbm_adr_i & ADR_MASK;
                        r_we    <= wbm_we_i;
                        r_sel   <= wbm_sel_i;
                        r_rem   <= (wbm_bl_i == '0) ? BL_W'(1) : wbm_bl_i;
                        r_cyc   <= 1'b1;
                        r_abort <= 1'b0;
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (!wbm_stb_i) begin
                        r_abort <= 1'b1;
                    end
                    if (w_beat_end) begin
                        if (w_abort) begin
                            r_cyc   <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (wbs_err_i || w_last) begin
                            r_cyc   <= 1'b0;
                            r_state <= S_DONE;
                        end
                        if (wbs_ack_i && !wbs_err_i) begin
                            r_adr <= (r_adr + ADR_STEP) & ADR_MASK;
                            r_rem <= r_rem - BL_W'(1);
                        end
                    end
                end
                // Hold here until the cache releases stb so a burst is never replayed.
                S_DONE: begin
                    if (!wbm_stb_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_burst_to_single.sv
// Scoreboard bench for wb_burst_to_single: directed bursts against a
// behavioural single-beat slave with programmable latency and error address.
module tb_wb_burst_to_single;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 8;

    logic            mclk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wbm_stb_i = 1'b0;
    logic [AW-1:0]   wbm_adr_i = '0;
    logic            wbm_we_i = 1'b0;
    logic [DW-1:0]   wbm_dat_i = '0;
    logic [3:0]      wbm_sel_i = '0;
    logic [BW-1:0]   wbm_bl_i = '0;
    logic [DW-1:0]   wbm_dat_o;
    logic            wbm_ack_o, wbm_lack_o, wbm_err_o;
    logic            wbs_cyc_o, wbs_stb_o, wbs_we_o;
    logic [AW-1:0]   wbs_adr_o;
    logic [DW-1:0]   wbs_dat_o;
    logic [3:0]      wbs_sel_o;
    logic [DW-1:0]   wbs_dat_i;
    logic            wbs_ack_i, wbs_err_i;

    always #5 mclk = ~mclk;

    wb_burst_to_single #(.WB_AW(AW), .WB_DW(DW), .BL_W(BW)) dut (
        .mclk(mclk), .rst_n(rst_n),
        .wbm_stb_i(wbm_stb_i), .wbm_adr_i(wbm_adr_i), .wbm_we_i(wbm_we_i),
        .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i), .wbm_bl_i(wbm_bl_i),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_lack_o(wbm_lack_o),
        .wbm_err_o(wbm_err_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_adr_o(wbs_adr_o),
        .wbs_we_o(wbs_we_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i)
    );

    typedef struct packed {
        logic        ack;
        logic        lack;
        logic        err;
        logic        chk;
        logic [31:0] dat;
    } up_t;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } sl_t;

    up_t         up_q[$];
    sl_t         sl_q[$];
    up_t         m_up;
    sl_t         m_sl;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] wd [0:31];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic exp_up(input logic a, input logic l, input logic e, input logic c, input logic [31:0] d);
        up_t x;
        x.ack = a; x.lack = l; x.err = e; x.chk = c; x.dat = d;
        up_q.push_back(x);
    endtask

    task automatic exp_sl(input logic [31:0] a, input logic we, input logic [3:0] sel, input logic [31:0] d);
        sl_t x;
        x.adr = a; x.we = we; x.sel = sel; x.dat = d;
        sl_q.push_back(x);
    endtask

    // Behavioural slave: word memory, ack after s_lat strobe cycles, err at s_err_adr.
    logic [31:0] mem [0:4095];
    bit          mem_ok = 1'b0;
    int          s_cnt;
    int          s_lat = 1;
    logic [31:0] s_err_adr = '1;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    always @(posedge mclk) begin
        if (!rst_n) begin
            wbs_ack_i <= 1'b0;
            wbs_err_i <= 1'b0;
            wbs_dat_i <= '0;
            s_cnt     <= 0;
            if (!mem_ok) begin
                for (int i = 0; i < 4096; i++)
                    mem[i] <= (i == 'h40) ? 32'hA5A5_0001 : (32'hD000_0000 | 32'(i << 2));
                mem_ok <= 1'b1;
            end
        end else if (wbs_cyc_o && wbs_stb_o && !wbs_ack_i && !wbs_err_i) begin
            if (s_cnt >= s_lat - 1) begin
                s_cnt <= 0;
                if (wbs_adr_o == s_err_adr) begin
                    wbs_err_i <= 1'b1;
                end else begin
                    wbs_ack_i <= 1'b1;
                    if (wbs_we_o) mem[wbs_adr_o[13:2]] <= merge(mem[wbs_adr_o[13:2]], wbs_dat_o, wbs_sel_o);
                    else          wbs_dat_i <= mem[wbs_adr_o[13:2]];
                end
            end else begin
                s_cnt <= s_cnt + 1;
            end
        end else begin
            wbs_ack_i <= 1'b0;
            wbs_err_i <= 1'b0;
        end
    end

    // Monitor: pops expected upstream responses and slave accesses as they appear.
    always @(negedge mclk) begin
        if (rst_n && (wbm_ack_o || wbm_lack_o || wbm_err_o)) begin
            if (up_q.size() == 0) begin
                check("up_unexpected", {61'd0, wbm_ack_o, wbm_lack_o, wbm_err_o}, 64'd0);
            end else begin
                m_up = up_q.pop_front();
                check("up_flags", {61'd0, wbm_ack_o, wbm_lack_o, wbm_err_o}, {61'd0, m_up.ack, m_up.lack, m_up.err});
                if (m_up.chk) check("up_rdata", wbm_dat_o, m_up.dat);
            end
        end
        if (rst_n && (wbs_ack_i || wbs_err_i)) begin
            if (sl_q.size() == 0) begin
                check("sl_unexpected", wbs_adr_o, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                m_sl = sl_q.pop_front();
                check("sl_adr", wbs_adr_o, m_sl.adr);
                check("sl_we_sel", {59'd0, wbs_we_o, wbs_sel_o}, {59'd0, m_sl.we, m_sl.sel});
                if (m_sl.we) check("sl_wdata", wbs_dat_o, m_sl.dat);
            end
        end
    end

    task automatic run_burst(input logic [31:0] adr, input int bl, input logic we,
                             input logic [3:0] sel, input int rst_at, input int hold);
        int beat = 0;
        int cyc  = 0;
        bit done = 1'b0;
        @(posedge mclk); #1;
        wbm_adr_i = adr; wbm_bl_i = BW'(bl); wbm_we_i = we; wbm_sel_i = sel;
        wbm_dat_i = wd[0]; wbm_stb_i = 1'b1;
        while (!done) begin
            @(negedge mclk);
            cyc++;
            if (wbm_err_o) done = 1'b1;
            else if (wbm_ack_o) begin
                beat++;
                if (wbm_lack_o) done = 1'b1;
            end
            if (!done && rst_at != 0 && beat == rst_at - 1 && wbs_cyc_o && !wbs_ack_i) begin
                rst_n = 1'b0;
                wbm_stb_i = 1'b0;
                #1;
                check("rst_ctrl", {58'd0, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbm_ack_o, wbm_lack_o, wbm_err_o}, 64'd0);
                check("rst_adr", wbs_adr_o, 64'd0);
                check("rst_sel", wbs_sel_o, 64'd0);
                $display("burst adr=%h bl=%0d we=%0b reset during beat %0d", adr, bl, we, rst_at);
                return;
            end
            if (!done && cyc > 400) begin
                check("burst_timeout", cyc, 64'd0);
                done = 1'b1;
            end
            @(posedge mclk); #1;
            if (!done) wbm_dat_i = wd[beat];
        end
        repeat (hold) begin
            @(negedge mclk);
            check("done_hold", {61'd0, wbs_cyc_o, wbm_ack_o, wbm_lack_o}, 64'd0);
            @(posedge mclk); #1;
        end
        wbm_stb_i = 1'b0;
        $display("burst adr=%h bl=%0d we=%0b sel=%h beats_acked=%0d cycles=%0d", adr, bl, we, sel, beat, cyc);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) wd[i] = '0;
        repeat (3) @(negedge mclk);
        check("reset_ctrl", {58'd0, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbm_ack_o, wbm_lack_o, wbm_err_o}, 64'd0);
        check("reset_adr", wbs_adr_o, 64'd0);
        check("reset_sel", wbs_sel_o, 64'd0);
        rst_n = 1'b1;

        // Single-beat read, stb held three cycles past lack.
        s_lat = 1;
        exp_sl(32'h100, 1'b0, 4'hF, 32'h0);
        exp_up(1, 1, 0, 1, 32'hA5A5_0001);
        run_burst(32'h100, 1, 1'b0, 4'hF, 0, 3);

        // 32-beat read, two-cycle slave.
        s_lat = 2;
        for (int i = 0; i < 32; i++) begin
            exp_sl(32'h2000 + 32'(4 * i), 1'b0, 4'hF, 32'h0);
            exp_up(1, (i == 31), 0, 1, 32'hD000_2000 + 32'(4 * i));
        end
        run_burst(32'h2000, 32, 1'b0, 4'hF, 0, 0);

        // Partial-byte write then read-back.
        s_lat = 1;
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'h1111_1111 * 32'(i + 1);
            exp_sl(32'h40 + 32'(4 * i), 1'b1, 4'b0101, wd[i]);
            exp_up(1, (i == 3), 0, 0, 32'h0);
        end
        run_burst(32'h40, 4, 1'b1, 4'b0101, 0, 0);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] v;
            v = 8'(8'h11 * (i + 1));
            exp_sl(32'h40 + 32'(4 * i), 1'b0, 4'hF, 32'h0);
            exp_up(1, (i == 3), 0, 1, {8'hD0, v, 8'h00, v});
        end
        run_burst(32'h40, 4, 1'b0, 4'hF, 0, 0);

        // Slave error on third beat of an 8-beat read.
        s_err_adr = 32'h3008;
        exp_sl(32'h3000, 1'b0, 4'hF, 32'h0);
        exp_sl(32'h3004, 1'b0, 4'hF, 32'h0);
        exp_sl(32'h3008, 1'b0, 4'hF, 32'h0);
        exp_up(1, 0, 0, 1, 32'hD000_3000);
        exp_up(1, 0, 0, 1, 32'hD000_3004);
        exp_up(0, 1, 1, 0, 32'h0);
        run_burst(32'h3000, 8, 1'b0, 4'hF, 0, 3);
        s_err_adr = '1;

        // bl=0 means one beat; misaligned start address is word-aligned.
        exp_sl(32'h80, 1'b0, 4'hF, 32'h0);
        exp_up(1, 1, 0, 1, 32'hD000_0080);
        run_burst(32'h80, 0, 1'b0, 4'hF, 0, 0);
        exp_sl(32'h804, 1'b0, 4'hF, 32'h0);
        exp_sl(32'h808, 1'b0, 4'hF, 32'h0);
        exp_up(1, 0, 0, 1, 32'hD000_0804);
        exp_up(1, 1, 0, 1, 32'hD000_0808);
        run_burst(32'h806, 2, 1'b0, 4'hF, 0, 0);

        // Reset during beat 5 of a 16-beat read, then a fresh 2-beat read.
        s_lat = 2;
        for (int i = 0; i < 4; i++) begin
            exp_sl(32'h400 + 32'(4 * i), 1'b0, 4'hF, 32'h0);
            exp_up(1, 0, 0, 1, 32'hD000_0400 + 32'(4 * i));
        end
        run_burst(32'h400, 16, 1'b0, 4'hF, 5, 0);
        repeat (3) @(negedge mclk);
        rst_n = 1'b1;
        exp_sl(32'h500, 1'b0, 4'hF, 32'h0);
        exp_sl(32'h504, 1'b0, 4'hF, 32'h0);
        exp_up(1, 0, 0, 1, 32'hD000_0500);
        exp_up(1, 1, 0, 1, 32'hD000_0504);
        run_burst(32'h500, 2, 1'b0, 4'hF, 0, 0);

        // Back-to-back bursts with a one-cycle stb gap.
        s_lat = 1;
        exp_sl(32'h600, 1'b0, 4'hF, 32'h0);
        exp_sl(32'h604, 1'b0, 4'hF, 32'h0);
        exp_up(1, 0, 0, 1, 32'hD000_0600);
        exp_up(1, 1, 0, 1, 32'hD000_0604);
        run_burst(32'h600, 2, 1'b0, 4'hF, 0, 0);
        for (int i = 0; i < 3; i++) begin
            exp_sl(32'h700 + 32'(4 * i), 1'b0, 4'hF, 32'h0);
            exp_up(1, (i == 2), 0, 1, 32'hD000_0700 + 32'(4 * i));
        end
        run_burst(32'h700, 3, 1'b0, 4'hF, 0, 0);

        repeat (5) @(negedge mclk);
        check("idle_cyc", {63'd0, wbs_cyc_o}, 64'd0);
        check("up_q_left", up_q.size(), 64'd0);
        check("sl_q_left", sl_q.size(), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_burst_to_single.md
Name: wb_burst_to_single

Overview:
- Bridge on the downstream side of the data cache's application port.
- Converts the cache's burst Wishbone request (stb, adr, bl, ack per beat, lack on last beat) into a sequence of classic single-beat Wishbone cycles (cyc/stb/ack) for slaves without burst support.
- Generates per-beat incrementing addresses, counts beats, and signals last-ack and errors back to the cache.

Parameters:
- WB_AW, 32, address width.
- WB_DW, 32, data width.
- BL_W, 8, burst-length field width.

Ports:
- mclk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- wbm_stb_i  input  1  burst request from cache, held until lack or err.
- wbm_adr_i  input  WB_AW  burst start address (word aligned).
- wbm_we_i  input  1  1=write burst.
- wbm_dat_i  input  WB_DW  write data, current beat; cache advances it the cycle after each ack.
- wbm_sel_i  input  WB_DW/8  byte enables, applied to every beat.
- wbm_bl_i  input  BL_W  burst length in words.
- wbm_dat_o  output  WB_DW  read data, valid with wbm_ack_o.
- wbm_ack_o  output  1  per-beat acknowledge.
- wbm_lack_o  output  1  last-beat acknowledge.
- wbm_err_o  output  1  error, one-cycle pulse.
- wbs_cyc_o  output  1  slave cycle.
- wbs_stb_o  output  1  slave strobe.
- wbs_adr_o  output  WB_AW  slave address.
- wbs_we_o  output  1  slave write.
- wbs_dat_o  output  WB_DW  slave write data.
- wbs_sel_o  output  WB_DW/8  slave byte enables.
- wbs_dat_i  input  WB_DW  slave read data.
- wbs_ack_i  input  1  slave acknowledge.
- wbs_err_i  input  1  slave error.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_sel_o are 0.
  - Beat counter is 0.
  - wbm_ack_o, wbm_lack_o, wbm_err_o are 0.
  - Asserting reset mid-burst drops the slave cycle immediately; there is no completion and no upstream ack.
- FSM has three states: IDLE, XFER, DONE.
- IDLE, on wbm_stb_i=1:
  - Register the address, we, sel, and remaining-beat count.
  - remaining = (wbm_bl_i==0) ? 1 : wbm_bl_i.
  - Next cycle: wbs_cyc_o=wbs_stb_o=1, state XFER. Latency from stb to slave strobe is 1 cycle.
- XFER:
  - wbs_adr_o, wbs_we_o, wbs_sel_o are registered. wbs_dat_o = wbm_dat_i (combinational pass-through).
  - On wbs_ack_i:
    - wbm_ack_o=1 in the same cycle (combinational).
    - wbm_dat_o = wbs_dat_i.
    - wbm_lack_o=1 if remaining==1.
    - Address += WB_DW/8, remaining -= 1.
    - If remaining was >1: stay in XFER, cyc/stb held high, next beat presented the following cycle (back-to-back, no idle cycle).
    - If remaining was 1: cyc/stb drop next cycle, go to DONE.
  - On wbs_err_i (priority over ack):
    - wbm_err_o=1 and wbm_lack_o=1 for that cycle; wbm_ack_o=0.
    - Drop cyc/stb next cycle, go to DONE. Remaining beats are discarded.
  - If wbm_stb_i falls while in XFER (upstream abort): the current slave beat still completes, its upstream ack is suppressed, no further beats are issued, then go to IDLE.
- DONE: wait until wbm_stb_i=0, then go to IDLE. This prevents a held stb from restarting the burst. Minimum gap between bursts is 1 cycle.
- Address arithmetic is linear modulo 2^WB_AW, with no line wrap. Low log2(WB_DW/8) address bits are forced to 0.
- wbm_ack_o, wbm_lack_o, wbm_err_o are never asserted outside XFER.
- Exactly bl beats (1 when bl=0) are issued per burst unless an error or abort occurs.

Test Plan:
- Read, bl=1, adr=0x100, slave ack latency 1, mem[0x100]=0xA5A5_0001:
  - One slave cycle at 0x100.
  - wbm_ack_o and wbm_lack_o high together, wbm_dat_o=0xA5A5_0001.
  - FSM in DONE until stb falls.
- Read, bl=32, adr=0x2000, slave ack latency 2:
  - 32 slave cycles, addresses 0x2000..0x207C.
  - 32 wbm_ack_o pulses; wbm_lack_o only on the 32nd; data matches memory.
- Write, bl=4, adr=0x40, sel=4'b0101, data 0x11111111..0x44444444:
  - Slave sees 4 writes at 0x40/44/48/4C, each with sel 0101.
  - Memory reflects only bytes 0 and 2.
- Read, bl=8, slave wbs_err_i on beat 3:
  - Two normal acks, then wbm_err_o=wbm_lack_o=1 on beat 3.
  - No slave cycle to 0x0C-offset or beyond.
- bl=0 read at 0x80: exactly one slave beat, with lack.
- rst_n low during beat 5 of a 16-beat burst:
  - All outputs are 0 asynchronously.
  - After release, a new bl=2 burst completes correctly.
- Two back-to-back bursts, stb re-asserted 1 cycle after drop: second burst starts correctly, with no spurious beat from the first.
